// File: rtl/mctrl_pkg.sv
// rtl/mctrl_pkg.sv - state, opcode and datapath-select encodings for multicycle_ctrl
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  // Only beq is supported among branches, so funct3 matters for OP_BRANCH alone.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
    state_t nxt;
    case (op)
      OP_LOAD, OP_STORE: nxt = S_MEMADR;
      OP_RTYPE:          nxt = S_EXEC;
      OP_BRANCH:         nxt = (f3 == F3_BEQ) ? S_BRANCH : S_ILLEGAL;
      default:           nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mctrl_wait_timer.sv
// rtl/mctrl_wait_timer.sv - memory wait counter and timeout compare
module mctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  input  logic restart,
  output logic timeout
);

  localparam bit               TMO_EN = (MEM_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] LIMIT  = TMO_W'(MEM_TIMEOUT);

  logic [TMO_W-1:0] cnt;

  // An ack in the limit cycle wins over the timeout.
  assign timeout = TMO_EN && req && !ack && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!req || ack || timeout || restart) begin
      cnt <= '0;
    end else if (TMO_EN) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV64 control FSM (ld/sd/beq/R-type)
// Optional performance counters under MCTRL_PERF_EN.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8
`ifdef MCTRL_PERF_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
`ifdef MCTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_t state, state_nxt;
  logic   fetch_pending, fetch_pending_nxt;
  logic   fetch_req;
  logic   timeout;
  logic   restart;

  // alu_zero qualifies pc_write_cond inside the datapath; the FSM never needs it.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  // run is only looked at until a fetch request is outstanding.
  assign fetch_req = (state == S_FETCH) && (run || fetch_pending);
  assign restart   = (state_nxt != state);

  mctrl_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (mem_req),
    .ack    (mem_ack),
    .restart(restart),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      fetch_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      fetch_pending <= fetch_pending_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    fetch_pending_nxt = 1'b0;
    mem_req           = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    iord              = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_write_cond     = 1'b0;
    pc_source         = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_RS2;
    alu_op            = ALU_ADD;
    mem_to_reg        = 1'b0;
    reg_write         = 1'b0;
    instr_done        = 1'b0;
    illegal_op        = 1'b0;
    bus_err           = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_req) begin
          mem_req   = 1'b1;
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ack) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
          end else begin
            fetch_pending_nxt = 1'b1;
          end
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_BRIMM;
        state_nxt = decode_next(opcode, funct3);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ack) begin
          state_nxt = S_MEMWB;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ack) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end else if (timeout) begin
          bus_err   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_FUNCT;
        state_nxt = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
        state_nxt     = S_FETCH;
      end
      // PC was already advanced in fetch, so dropping here skips the instruction.
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

`ifdef MCTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done && !illegal_op) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       mem_ack;
  logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic       pc_write_cond, pc_source, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       mem_to_reg, reg_write, instr_done, illegal_op, bus_err;
`ifdef MCTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .funct3       (funct3),
    .alu_zero     (alu_zero),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .instr_done   (instr_done),
    .illegal_op   (illegal_op),
    .bus_err      (bus_err)
`ifdef MCTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  logic [17:0] act;
  assign act = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond,
                pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
                instr_done, illegal_op, bus_err};

  function automatic logic [17:0] mk(input logic req, rd, wr, io, irw, pcw, pcc, pcs, asa,
                                     input logic [1:0] asb, aop,
                                     input logic mtr, rw, dn, il, be);
    return {req, rd, wr, io, irw, pcw, pcc, pcs, asa, asb, aop, mtr, rw, dn, il, be};
  endfunction

  typedef struct {
    logic [17:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [6:0]       op;
    logic [2:0]       f3;
    logic             zero;
    int               len;
    logic [4:0][17:0] seq;
    string            name;
  } vec_t;
  vec_t vecs[7];

  logic [17:0] w_idle, w_fetch_wait, w_fetch_ack, w_fetch_tmo, w_decode, w_memadr;
  logic [17:0] w_memrd_wait, w_memrd_ack, w_memrd_tmo, w_memwb, w_memwr_wait, w_memwr_ack;
  logic [17:0] w_exec, w_rwb, w_branch, w_illegal;

  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  task automatic cyc(input logic r, input logic a, input logic [17:0] exp, input string name);
    sb_t e;
    run     = r;
    mem_ack = a;
    e.exp   = exp;
    e.name  = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    w_idle       = '0;
    w_fetch_wait = mk(1,1,0,0,0,0,0,0,0,2'b01,2'b00,0,0,0,0,0);
    w_fetch_ack  = mk(1,1,0,0,1,1,0,0,0,2'b01,2'b00,0,0,0,0,0);
    w_fetch_tmo  = mk(1,1,0,0,0,0,0,0,0,2'b01,2'b00,0,0,0,0,1);
    w_decode     = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0,0,0,0);
    w_memadr     = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,0,0);
    w_memrd_wait = mk(1,1,0,1,0,0,0,0,0,2'b00,2'b00,0,0,0,0,0);
    w_memrd_ack  = w_memrd_wait;
    w_memrd_tmo  = mk(1,1,0,1,0,0,0,0,0,2'b00,2'b00,0,0,0,0,1);
    w_memwb      = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,1,1,1,0,0);
    w_memwr_wait = mk(1,0,1,1,0,0,0,0,0,2'b00,2'b00,0,0,0,0,0);
    w_memwr_ack  = mk(1,0,1,1,0,0,0,0,0,2'b00,2'b00,0,0,1,0,0);
    w_exec       = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,0,0);
    w_rwb        = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1,1,0,0);
    w_branch     = mk(0,0,0,0,0,0,1,1,1,2'b00,2'b01,0,0,1,0,0);
    w_illegal    = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,1,0);

    vecs[0] = '{7'b0000011, 3'b011, 1'b0, 5, {w_memwb, w_memrd_ack, w_memadr, w_decode, w_fetch_ack}, "ld"};
    vecs[1] = '{7'b0100011, 3'b011, 1'b0, 4, {18'd0, w_memwr_ack, w_memadr, w_decode, w_fetch_ack}, "sd"};
    vecs[2] = '{7'b0110011, 3'b000, 1'b0, 4, {18'd0, w_rwb, w_exec, w_decode, w_fetch_ack}, "rtype"};
    vecs[3] = '{7'b1100011, 3'b000, 1'b1, 3, {18'd0, 18'd0, w_branch, w_decode, w_fetch_ack}, "beq_z1"};
    vecs[4] = '{7'b1100011, 3'b000, 1'b0, 3, {18'd0, 18'd0, w_branch, w_decode, w_fetch_ack}, "beq_z0"};
    vecs[5] = '{7'b1111111, 3'b000, 1'b0, 3, {18'd0, 18'd0, w_illegal, w_decode, w_fetch_ack}, "ill_op"};
    vecs[6] = '{7'b1100011, 3'b001, 1'b0, 3, {18'd0, 18'd0, w_illegal, w_decode, w_fetch_ack}, "ill_f3"};

    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0;
    opcode = '0; funct3 = '0; alu_zero = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, w_idle, "reset_outputs");
    rst_n = 1'b1;
    cyc(0, 1, w_idle, "ack_without_req");
    cyc(0, 0, w_idle, "stray_ack_ignored");

    foreach (vecs[i]) begin
      opcode   = vecs[i].op;
      funct3   = vecs[i].f3;
      alu_zero = vecs[i].zero;
      for (int j = 0; j < vecs[i].len; j++)
        cyc(1, 1, vecs[i].seq[j], $sformatf("%s_c%0d", vecs[i].name, j + 1));
      cyc(0, 0, w_idle, {vecs[i].name, "_back_in_fetch"});
    end

    opcode = 7'b0100011; funct3 = 3'b011;
    cyc(1, 1, w_fetch_ack, "sd_slow_fetch");
    cyc(1, 1, w_decode, "sd_slow_decode");
    cyc(1, 1, w_memadr, "sd_slow_memadr");
    for (int k = 0; k < 3; k++) cyc(1, 0, w_memwr_wait, $sformatf("sd_slow_wait%0d", k));
    cyc(1, 1, w_memwr_ack, "sd_slow_ack");
    cyc(0, 0, w_idle, "sd_slow_back_in_fetch");

    opcode = 7'b0110011; funct3 = 3'b000;
    cyc(1, 0, w_fetch_wait, "run_drop_req");
    cyc(0, 0, w_fetch_wait, "run_drop_req_held");
    cyc(0, 1, w_fetch_ack, "run_drop_ack");
    cyc(0, 0, w_decode, "run_drop_decode");
    cyc(0, 0, w_exec, "run_drop_exec");
    cyc(0, 0, w_rwb, "run_drop_rwb");
    cyc(0, 0, w_idle, "run_drop_back_in_fetch");

    opcode = 7'b1100011; funct3 = 3'b000; alu_zero = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1, 0, w_fetch_wait, $sformatf("fetch_wait%0d", k));
    cyc(1, 0, w_fetch_tmo, "fetch_timeout");
    for (int k = 0; k < 4; k++) cyc(1, 0, w_fetch_wait, $sformatf("retry_wait%0d", k));
    cyc(1, 1, w_fetch_ack, "ack_at_limit");
    cyc(0, 0, w_decode, "retry_decode");
    cyc(0, 0, w_branch, "retry_branch");
    cyc(0, 0, w_idle, "retry_back_in_fetch");

    for (int k = 0; k < 4; k++) cyc(1, 0, w_fetch_wait, $sformatf("tmo2_wait%0d", k));
    cyc(1, 0, w_fetch_tmo, "fetch_timeout2");
    cyc(0, 0, w_idle, "req_dropped_after_timeout");

    opcode = 7'b0000011; funct3 = 3'b011;
    cyc(1, 1, w_fetch_ack, "ldtmo_fetch");
    cyc(0, 0, w_decode, "ldtmo_decode");
    cyc(0, 0, w_memadr, "ldtmo_memadr");
    for (int k = 0; k < 4; k++) cyc(0, 0, w_memrd_wait, $sformatf("ldtmo_wait%0d", k));
    cyc(0, 0, w_memrd_tmo, "memrd_timeout");
    cyc(0, 0, w_idle, "memrd_timeout_back_in_fetch");

    cyc(1, 1, w_fetch_ack, "rst_fetch");
    cyc(0, 0, w_decode, "rst_decode");
    cyc(0, 0, w_memadr, "rst_memadr");
    cyc(0, 0, w_memrd_wait, "rst_memrd");
    rst_n = 1'b0;
    #1;
`ifdef MCTRL_PERF_EN
    check_val("cycle_cnt_in_reset", cycle_cnt, 32'd0);
    check_val("instret_cnt_in_reset", instret_cnt, 32'd0);
`endif
    cyc(0, 0, w_idle, "reset_in_memrd");
    rst_n = 1'b1;
    cyc(0, 0, w_idle, "after_reset_idle");
    opcode = 7'b0110011; funct3 = 3'b000;
    cyc(1, 1, w_fetch_ack, "post_rst_fetch");
    cyc(0, 0, w_decode, "post_rst_decode");
    cyc(0, 0, w_exec, "post_rst_exec");
    cyc(0, 0, w_rwb, "post_rst_rwb");
    cyc(0, 0, w_idle, "post_rst_back_in_fetch");
`ifdef MCTRL_PERF_EN
    check_val("instret_after_reset", instret_cnt, 32'd1);
`endif
    check_val("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV64 datapath: register file, 64-bit adder/ALU, immediate generator, and a single shared instruction/data memory.
- Sequences fetch, decode, execute, memory and writeback for ld, sd, beq and R-type instructions.
- Drives all datapath mux selects and write enables.
- Owns the request/acknowledge handshake to the shared memory port.

Parameters:
- MEM_TIMEOUT, 16: cycles a memory request may wait for mem_ack before it is abandoned. 0 disables the timeout.
- TMO_W, 8: width of the wait counter. MEM_TIMEOUT must be < 2^TMO_W.
- CNT_W, 32: width of the performance counters (used only under MCTRL_PERF_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  permits a new fetch; sampled only in S_FETCH while no request is outstanding
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- alu_zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_read  out  1  request is a read
- mem_write  out  1  request is a write
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write when alu_zero = 1
- pc_source  out  1  PC source: 0 = ALU result, 1 = ALUOut
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs1
- alu_src_b  out  2  ALU B: 00 = rs2, 01 = const 4, 10 = imm, 11 = imm (branch target)
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct fields
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse when an instruction retires or is dropped
- illegal_op  out  1  one-cycle pulse for an unsupported instruction
- bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- State register is 4-bit. Reset forces S_FETCH and clears the wait counter.
- Outputs are a Moore decode of state. Exceptions: ir_write, pc_write and instr_done in memory states are gated by mem_ack (Mealy).
- Outputs immediately after reset with run = 0: all 0.
- S_FETCH:
  - mem_req = mem_read = run; iord = 0; alu_src_a = 0; alu_src_b = 01; alu_op = 00.
  - On mem_ack: ir_write = 1, pc_write = 1 (PC <= PC + 4), go to S_DECODE.
- Handshake:
  - Once mem_req is high it is held, with address and direction stable, until mem_ack.
  - run falling during an outstanding fetch has no effect.
  - mem_ack while mem_req = 0 is ignored.
- S_DECODE (1 cycle): alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXEC
  - 1100011 with funct3 = 000 -> S_BRANCH
  - any other opcode or funct3 -> S_ILLEGAL
- S_MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next S_MEMRD for a load, S_MEMWR for a store.
- S_MEMRD: mem_req = mem_read = 1, iord = 1. On ack -> S_MEMWB.
- S_MEMWB: reg_write = 1, mem_to_reg = 1, instr_done = 1 -> S_FETCH.
- S_MEMWR: mem_req = mem_write = 1, iord = 1. On ack: instr_done = 1 -> S_FETCH.
- S_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> S_RWB.
- S_RWB: reg_write = 1, mem_to_reg = 0, instr_done = 1 -> S_FETCH.
- S_BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 1, instr_done = 1 -> S_FETCH.
- S_ILLEGAL: illegal_op = 1, instr_done = 1, no register or memory writes -> S_FETCH. The instruction is skipped because PC was already advanced.
- Zero-wait latency (first fetch cycle to the cycle after instr_done): ld 5, sd 4, R-type 4, beq 3 cycles.
- Timeout:
  - Wait counter increments each cycle mem_req = 1 and mem_ack = 0; it clears on ack or on a state change.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT: bus_err pulses, mem_req drops, state goes to S_FETCH with no PC or register write.
  - A timeout during a fetch retries the same PC.
  - mem_ack arriving in the timeout cycle wins; no bus_err.
- Reset asserted mid-instruction: immediate return to S_FETCH, all pulses cleared, the partial instruction is discarded.

Optional Feature:
- Macro: MCTRL_PERF_EN.
- Defined: adds output ports cycle_cnt [CNT_W-1:0] and instret_cnt [CNT_W-1:0].
  - cycle_cnt counts every cycle out of reset.
  - instret_cnt counts instr_done pulses, excluding illegal ones.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mctrl_pkg holds:
  - state encodings S_FETCH = 0 through S_ILLEGAL = 9, 4-bit
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE
  - alu_op and alu_src_b encodings
- One natural sub-module, mctrl_wait_timer: the wait counter and timeout compare.

Test Plan:
- ld (opcode 0000011), mem_ack every cycle a request is made -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write = 1 with mem_to_reg = 1 in cycle 5; instr_done pulses once.
- sd with mem_ack delayed 3 cycles in S_MEMWR -> mem_req, iord = 1 and mem_write stay stable for 4 cycles; no reg_write; instr_done coincides with ack.
- beq with alu_zero = 1, then with alu_zero = 0 -> pc_write_cond = 1, pc_source = 1 for one cycle in both; 3-cycle latency.
- Illegal cases, opcode 1111111 and beq with funct3 = 001 -> illegal_op and instr_done pulse once each; no reg_write or mem_write.
- MEM_TIMEOUT = 4 with mem_ack never asserted in fetch -> bus_err pulses after 4 waiting cycles; fetch retries with pc_write never asserted. Ack exactly at count 4 -> no bus_err.
- rst_n pulsed low during S_MEMRD -> asynchronous return to S_FETCH, all outputs 0 with run = 0; under MCTRL_PERF_EN both counters read 0.
